// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard unit for a 5-stage pipelined RISC-V style core.
//
// Purpose:
//   Detects load-use hazards (stall Fetch/Decode, bubble Execute), resolves
//   control hazards from a taken branch/jump in Execute (flush Decode and
//   Execute), and selects ALU operand forwarding from Memory/Writeback.
//   The pipeline is held frozen in IDLE until trigger_i is first sampled high.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   trigger_i                   run enable; only its first high sample matters
//   Rs1D_i, Rs2D_i              Decode source registers
//   Rs1E_i, Rs2E_i, RdE_i       Execute source/destination registers
//   ResultSrcE0_i               Execute instruction is a load
//   PCSrcE_i                    branch/jump taken in Execute
//   RdM_i, RegWriteM_i          Memory stage destination / write enable
//   RdW_i, RegWriteW_i          Writeback stage destination / write enable
//   ForwardAE_o, ForwardBE_o    00 regfile, 10 ALUResultM, 01 ResultW
//   StallF_o, StallD_o          hold Fetch / Decode registers
//   FlushD_o, FlushE_o          clear Decode / Execute registers
//   run_o                       high while the FSM is in RUN
//   stall_cnt_o, flush_cnt_o    performance counters
//
// Configuration:
//   HAZARD_CTRL_PERF_EN  defined   -> stall/flush counters implemented
//                        undefined -> counters absent, outputs read zero
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger_i,
  input  logic [4:0]  Rs1D_i,
  input  logic [4:0]  Rs2D_i,
  input  logic [4:0]  Rs1E_i,
  input  logic [4:0]  Rs2E_i,
  input  logic [4:0]  RdE_i,
  input  logic        ResultSrcE0_i,
  input  logic        PCSrcE_i,
  input  logic [4:0]  RdM_i,
  input  logic [4:0]  RdW_i,
  input  logic        RegWriteM_i,
  input  logic        RegWriteW_i,
  output logic [1:0]  ForwardAE_o,
  output logic [1:0]  ForwardBE_o,
  output logic        StallF_o,
  output logic        StallD_o,
  output logic        FlushD_o,
  output logic        FlushE_o,
  output logic        run_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    LDSTALL = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   load_use;

  // Memory stage is newer than Writeback, so it takes priority; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == rs))
      return 2'b10;
    else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign load_use = ResultSrcE0_i && (RdE_i != 5'd0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A taken branch squashes the dependent instruction in
  // Decode, so it cancels any load-use stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (trigger_i) state_d = RUN;
      RUN, LDSTALL: state_d = (!PCSrcE_i && load_use) ? LDSTALL : RUN;
      default:      state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    StallF_o    = 1'b0;
    StallD_o    = 1'b0;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    run_o       = 1'b0;
    case (state_q)
      RUN, LDSTALL: begin
        run_o       = (state_q == RUN);
        ForwardAE_o = fwd_sel(Rs1E_i);
        ForwardBE_o = fwd_sel(Rs2E_i);
        if (PCSrcE_i) begin
          FlushD_o = 1'b1;
          FlushE_o = 1'b1;
        end else if (load_use) begin
          StallF_o = 1'b1;
          StallD_o = 1'b1;
          FlushE_o = 1'b1;
        end
      end
      default: begin
        // IDLE (and any unreachable encoding): freeze fetch/decode, keep a
        // bubble in Execute.
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
    endcase
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // StallD_o is also high in IDLE, so gate on being out of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if ((state_q != IDLE) && StallD_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (FlushD_o)                      flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- scoreboard bench for hazard_ctrl.
// The driver applies one stimulus vector per cycle at the falling edge and
// pushes the reference model's expected outputs; the monitor pops and
// compares later in the same low phase.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger_i;
  logic [4:0]  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic        ResultSrcE0_i, PCSrcE_i, RegWriteM_i, RegWriteW_i;
  logic [1:0]  ForwardAE_o, ForwardBE_o;
  logic        StallF_o, StallD_o, FlushD_o, FlushE_o, run_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .trigger_i(trigger_i),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .ResultSrcE0_i(ResultSrcE0_i), .PCSrcE_i(PCSrcE_i),
    .RdM_i(RdM_i), .RdW_i(RdW_i), .RegWriteM_i(RegWriteM_i),
    .RegWriteW_i(RegWriteW_i), .ForwardAE_o(ForwardAE_o),
    .ForwardBE_o(ForwardBE_o), .StallF_o(StallF_o), .StallD_o(StallD_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .run_o(run_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic       rstn, trig, lde, pcs, rwm, rww;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  } stim_t;

  typedef struct {
    logic [1:0]  fa, fb;
    logic        sf, sd, fd, fe, run;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: running flag, "bubble cycle" flag, event counts.
  bit          m_running = 0;
  bit          m_bubble  = 0;
  logic [31:0] m_sc = 0, m_fc = 0;

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (s.rwm && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic go(input stim_t s);
    exp_t e;
    bit   hazard;
    @(negedge clk);
    rst_n = s.rstn; trigger_i = s.trig;
    Rs1D_i = s.rs1d; Rs2D_i = s.rs2d; Rs1E_i = s.rs1e; Rs2E_i = s.rs2e;
    RdE_i = s.rde; ResultSrcE0_i = s.lde; PCSrcE_i = s.pcs;
    RdM_i = s.rdm; RdW_i = s.rdw; RegWriteM_i = s.rwm; RegWriteW_i = s.rww;
    #1;
    if (!s.rstn) begin
      m_running = 0; m_bubble = 0; m_sc = 0; m_fc = 0;
    end
    hazard = s.lde && (s.rde != 0) && (s.rde == s.rs1d || s.rde == s.rs2d);
    e = '{fa: 2'b00, fb: 2'b00, sf: 1'b1, sd: 1'b1, fd: 1'b0, fe: 1'b1,
          run: 1'b0, sc: 32'd0, fc: 32'd0};
    if (m_running) begin
      e.fa  = ref_fwd(s, s.rs1e);
      e.fb  = ref_fwd(s, s.rs2e);
      e.run = !m_bubble;
      e.sf  = !s.pcs && hazard;
      e.sd  = e.sf;
      e.fd  = s.pcs;
      e.fe  = s.pcs || hazard;
    end
`ifdef HAZARD_CTRL_PERF_EN
    e.sc = m_sc;
    e.fc = m_fc;
`endif
    exp_q.push_back(e);
    // Effect of the coming rising edge.
    if (s.rstn) begin
      if (!m_running) begin
        m_running = s.trig;
        m_bubble  = 0;
      end else begin
        if (e.sd) m_sc = m_sc + 1;
        if (e.fd) m_fc = m_fc + 1;
        m_bubble = e.sd;
      end
    end
  endtask

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: one expected entry per cycle, compared mid low phase.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ForwardAE", {30'd0, ForwardAE_o}, {30'd0, e.fa});
      chk("ForwardBE", {30'd0, ForwardBE_o}, {30'd0, e.fb});
      chk("StallF",    {31'd0, StallF_o},    {31'd0, e.sf});
      chk("StallD",    {31'd0, StallD_o},    {31'd0, e.sd});
      chk("FlushD",    {31'd0, FlushD_o},    {31'd0, e.fd});
      chk("FlushE",    {31'd0, FlushE_o},    {31'd0, e.fe});
      chk("run",       {31'd0, run_o},       {31'd0, e.run});
      chk("stall_cnt", stall_cnt_o, e.sc);
      chk("flush_cnt", flush_cnt_o, e.fc);
    end
  end

  function automatic stim_t quiet();
    stim_t s;
    s = '{rstn: 1'b1, trig: 1'b0, lde: 1'b0, pcs: 1'b0, rwm: 1'b0, rww: 1'b0,
          rs1d: 5'd1, rs2d: 5'd2, rs1e: 5'd0, rs2e: 5'd0, rde: 5'd0,
          rdm: 5'd0, rdw: 5'd0};
    return s;
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b0; trigger_i = 1'b0;
    Rs1D_i = 0; Rs2D_i = 0; Rs1E_i = 0; Rs2E_i = 0; RdE_i = 0;
    ResultSrcE0_i = 0; PCSrcE_i = 0; RdM_i = 0; RdW_i = 0;
    RegWriteM_i = 0; RegWriteW_i = 0;

    // Reset, then five idle cycles with trigger low.
    s = quiet(); s.rstn = 1'b0;
    repeat (2) go(s);
    s = quiet();
    repeat (5) go(s);
    s.trig = 1'b1; go(s);
    s.trig = 1'b0; go(s);              // running; trigger drop ignored
    go(s);

    // Load-use: lw x5 in E, Rs1D = x5.
    s = quiet(); s.lde = 1; s.rde = 5'd5; s.rs1d = 5'd5; go(s);
    s = quiet(); go(s);                // bubble cycle
    go(s);                             // back in RUN

    // Forwarding: M and W both write x3.
    s = quiet(); s.rwm = 1; s.rdm = 5'd3; s.rww = 1; s.rdw = 5'd3;
    s.rs1e = 5'd3; s.rs2e = 5'd3; go(s);
    s.rdm = 5'd0; go(s);
    s.rs1e = 5'd0; s.rs2e = 5'd0; s.rdw = 5'd0; go(s);

    // Load-use on x7 together with a taken branch.
    s = quiet(); s.lde = 1; s.rde = 5'd7; s.rs2d = 5'd7; s.pcs = 1; go(s);
    s = quiet(); go(s);

    // Load to x0 never stalls.
    s = quiet(); s.lde = 1; s.rde = 5'd0; s.rs1d = 5'd0; go(s);

    // Back-to-back load-use: second hazard arrives in the bubble cycle.
    s = quiet(); s.lde = 1; s.rde = 5'd9; s.rs1d = 5'd9; go(s);
    s.rde = 5'd4; s.rs2d = 5'd4; go(s);
    s = quiet(); go(s);

    // Reset during the bubble cycle.
    s = quiet(); s.lde = 1; s.rde = 5'd6; s.rs1d = 5'd6; go(s);
    s = quiet(); s.rstn = 0; s.lde = 1; s.rde = 5'd6; s.rs1d = 5'd6; go(s);
    s = quiet(); go(s);                // idle again, nothing pending
    s.trig = 1; go(s);
    s = quiet(); go(s);

`ifdef HAZARD_CTRL_PERF_EN
    // Counter wrap: preload all-ones, then one stall.
    #3;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #0;
    release dut.stall_cnt_q;
    m_sc = 32'hFFFF_FFFF;
    s = quiet(); go(s);
    s = quiet(); s.lde = 1; s.rde = 5'd8; s.rs1d = 5'd8; go(s);
    s = quiet(); go(s);
    go(s);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      s.rstn = ($urandom_range(0, 79) != 0);
      s.trig = ($urandom_range(0, 3) == 0);
      s.lde  = $urandom_range(0, 1);
      s.pcs  = ($urandom_range(0, 7) == 0);
      s.rwm  = $urandom_range(0, 1);
      s.rww  = $urandom_range(0, 1);
      s.rs1d = 5'($urandom_range(0, 7));
      s.rs2d = 5'($urandom_range(0, 7));
      s.rs1e = 5'($urandom_range(0, 7));
      s.rs2e = 5'($urandom_range(0, 7));
      s.rde  = 5'($urandom_range(0, 7));
      s.rdm  = 5'($urandom_range(0, 7));
      s.rdw  = 5'($urandom_range(0, 7));
      go(s);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
